// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched
// Autonomous scan scheduler in front of the SPI A2D interface. A period timer
// produces a tick every SCAN_PERIOD clocks. On each tick (when idle and enabled)
// the enabled channels 0..7 are converted in ascending order. Each 12-bit
// result lands in a per-channel register that can be read back by index.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_scan_en          enables the period timer and new scans
//   i_chnl_mask[7:0]   channel enables, sampled at scan start
//   i_clr_err          clears both sticky error flags
//   i_rd_chnl[2:0]     readback select -> o_rd_data[11:0] (combinational)
//   o_valid[7:0]       per-channel "holds a good result"
//   o_scan_done        one-clock pulse at the end of every scan
//   o_busy             high whenever the FSM is not idle
//   o_err_timeout      sticky: a conversion was abandoned by the watchdog
//   o_err_overrun      sticky: a tick arrived while a scan was in progress
//   o_strt_cnv         one-clock conversion start to the A2D interface
//   o_chnnl[2:0]       channel being converted (stable START through CONV)
//   i_cnv_cmplt        conversion complete from the A2D interface
//   i_res[11:0]        conversion result, valid with i_cnv_cmplt
module a2d_scan_sched #(
    parameter int unsigned SCAN_PERIOD = 50000,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scan_en,
    input  logic [7:0]  i_chnl_mask,
    input  logic        i_clr_err,
    input  logic [2:0]  i_rd_chnl,
    output logic [11:0] o_rd_data,
    output logic [7:0]  o_valid,
    output logic        o_scan_done,
    output logic        o_busy,
    output logic        o_err_timeout,
    output logic        o_err_overrun,
    output logic        o_strt_cnv,
    output logic [2:0]  o_chnnl,
    input  logic        i_cnv_cmplt,
    input  logic [11:0] i_res
);

    localparam int unsigned TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(SCAN_PERIOD - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StStart,
        StConv,
        StNext,
        StDone
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer;
    logic          w_tick;
    logic [2:0]    r_ptr, w_ptr_nxt;
    logic [7:0]    r_scan_mask, w_scan_mask_nxt;
    logic [WW-1:0] r_wdog, w_wdog_nxt;
    logic [7:0]    r_valid, w_valid_nxt;
    logic [11:0]   r_result [8];
    logic          w_res_we;
    logic          w_set_timeout;
    logic          w_set_overrun;
    logic          r_err_timeout;
    logic          r_err_overrun;

    // Period timer: free-runs while enabled, parked at 0 otherwise.
    assign w_tick = (r_timer == TMR_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (!i_scan_en || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_scan_mask_nxt = r_scan_mask;
        w_wdog_nxt      = r_wdog;
        w_valid_nxt     = r_valid;
        w_res_we        = 1'b0;
        w_set_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_tick && i_scan_en && (i_chnl_mask != 8'h00)) begin
                    w_scan_mask_nxt = i_chnl_mask;
                    w_ptr_nxt       = 3'd0;
                    w_state_nxt     = StSel;
                end
            end
            StSel: begin
                // One clock per skipped channel keeps the walk trivially simple.
                if (r_scan_mask[r_ptr]) begin
                    w_state_nxt = StStart;
                end else if (r_ptr == 3'd7) begin
                    w_state_nxt = StDone;
                end else begin
                    w_ptr_nxt = r_ptr + 3'd1;
                end
            end
            StStart: begin
                w_wdog_nxt  = '0;
                w_state_nxt = StConv;
            end
            StConv: begin
                w_wdog_nxt = r_wdog + 1'b1;
                // Completion wins over a coincident watchdog expiry.
                if (i_cnv_cmplt) begin
                    w_res_we           = 1'b1;
                    w_valid_nxt[r_ptr] = 1'b1;
                    w_state_nxt        = StNext;
                end else if (r_wdog == WD_LAST) begin
                    w_set_timeout      = 1'b1;
                    w_valid_nxt[r_ptr] = 1'b0;
                    w_state_nxt        = StNext;
                end
            end
            StNext: begin
                if (r_ptr == 3'd7) begin
                    w_state_nxt = StDone;
                end else begin
                    w_ptr_nxt   = r_ptr + 3'd1;
                    w_state_nxt = StSel;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign w_set_overrun = w_tick && (r_state != StIdle);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_ptr         <= 3'd0;
            r_scan_mask   <= 8'h00;
            r_wdog        <= '0;
            r_valid       <= 8'h00;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_scan_mask   <= w_scan_mask_nxt;
            r_wdog        <= w_wdog_nxt;
            r_valid       <= w_valid_nxt;
            // A set in the same cycle as a clear leaves the flag set.
            r_err_timeout <= w_set_timeout | (r_err_timeout & ~i_clr_err);
            r_err_overrun <= w_set_overrun | (r_err_overrun & ~i_clr_err);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_result[i] <= 12'h000;
            end
        end else if (w_res_we) begin
            r_result[r_ptr] <= i_res;
        end
    end

    // Moore outputs
    assign o_strt_cnv    = (r_state == StStart);
    assign o_scan_done   = (r_state == StDone);
    assign o_busy        = (r_state != StIdle);
    assign o_chnnl       = r_ptr;
    assign o_valid       = r_valid;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;
    assign o_rd_data     = r_result[i_rd_chnl];

endmodule

// File: tb/tb_a2d_scan_sched.sv
// Bench for a2d_scan_sched (SCAN_PERIOD=100, TIMEOUT=16). A small A2D model
// answers each strt_cnv after a per-channel latency (0 = never answers).
// Expected strt_cnv/scan_done pulses, with channel and absolute cycle, are
// queued by the stimulus; a monitor pops and compares each pulse it sees.
module tb_a2d_scan_sched;

    localparam int P  = 100;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        scan_en;
    logic [7:0]  chnl_mask;
    logic        clr_err;
    logic [2:0]  rd_chnl;
    logic [11:0] rd_data;
    logic [7:0]  valid;
    logic        scan_done;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    a2d_scan_sched #(
        .SCAN_PERIOD(P),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_scan_en    (scan_en),
        .i_chnl_mask  (chnl_mask),
        .i_clr_err    (clr_err),
        .i_rd_chnl    (rd_chnl),
        .o_rd_data    (rd_data),
        .o_valid      (valid),
        .o_scan_done  (scan_done),
        .o_busy       (busy),
        .o_err_timeout(err_timeout),
        .o_err_overrun(err_overrun),
        .o_strt_cnv   (strt_cnv),
        .o_chnnl      (chnnl),
        .i_cnv_cmplt  (cnv_cmplt),
        .i_res        (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       done;
        logic [2:0] ch;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    task automatic exp_start(input int ch, input int at);
        ev_t e;
        e.done = 1'b0;
        e.ch   = 3'(ch);
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int at);
        ev_t e;
        e.done = 1'b1;
        e.ch   = 3'd0;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (strt_cnv || scan_done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: strt_cnv=%0b scan_done=%0b chnnl=%0d (cycle %0d)",
                         strt_cnv, scan_done, chnnl, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", 32'(scan_done), 32'(mon_e.done));
                if (!mon_e.done) chk("chnnl", 32'(chnnl), 32'(mon_e.ch));
                chk("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    // ---------------- A2D model ----------------
    int          lat [8];
    logic [11:0] rv  [8];
    logic [2:0]  mch;

    initial begin
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        forever begin
            @(negedge clk);
            if (rst_n && strt_cnv && lat[chnnl] != 0) begin
                mch = chnnl;
                repeat (lat[mch]) @(posedge clk);
                #1;
                cnv_cmplt = 1'b1;
                res       = rv[mch];
                @(posedge clk);
                #1;
                cnv_cmplt = 1'b0;
                res       = 12'h000;
            end
        end
    end

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int t;
    int busy_cnt;

    initial begin
        for (int i = 0; i < 8; i++) begin
            lat[i] = 0;
            rv[i]  = 12'h000;
        end
        rst_n     = 1'b0;
        scan_en   = 1'b0;
        chnl_mask = 8'h00;
        clr_err   = 1'b0;
        rd_chnl   = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {strt_cnv, chnnl, busy, scan_done, valid, err_timeout, err_overrun, rd_data}, 32'd0);
        rst_n = 1'b1;
        at_cyc(cyc + 2);

        // Two scans of mask 05, latency 10.
        chnl_mask = 8'h05;
        lat[0] = 10; rv[0] = 12'h123;
        lat[2] = 10; rv[2] = 12'hABC;
        t = cyc + P - 1;
        scan_en = 1'b1;
        exp_start(0, t + 2); exp_start(2, t + 16); exp_done(t + 33);
        exp_start(0, t + P + 2); exp_start(2, t + P + 16); exp_done(t + P + 33);
        at_cyc(t + 33);
        chk("busy_in_done", 32'(busy), 32'd1);
        at_cyc(t + 34);
        chk("busy_after_done", 32'(busy), 32'd0);
        at_cyc(t + P + 40);
        scan_en = 1'b0;
        chk("valid_05", 32'(valid), 32'h05);
        rd_chnl = 3'd2; #1;
        chk("rd_ch2", 32'(rd_data), 32'hABC);
        rd_chnl = 3'd0; #1;
        chk("rd_ch0", 32'(rd_data), 32'h123);
        chk("no_errors", {30'd0, err_timeout, err_overrun}, 32'd0);

        // All channels, latency 5: starts every 8 clocks.
        at_cyc(cyc + 5);
        chnl_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            lat[i] = 5;
            rv[i]  = 12'h800 + 12'(i);
        end
        t = cyc + P - 1;
        scan_en = 1'b1;
        for (int k = 0; k < 8; k++) exp_start(k, t + 2 + 8 * k);
        exp_done(t + 65);
        at_cyc(t + 70);
        scan_en = 1'b0;
        chk("valid_ff", 32'(valid), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            rd_chnl = 3'(i); #1;
            chk("rd_all", 32'(rd_data), 32'h800 + 32'(i));
        end

        // Channel 3 never answers: timeout after 16 CONV clocks.
        at_cyc(cyc + 5);
        chnl_mask = 8'h08;
        lat[3] = 0;
        t = cyc + P - 1;
        scan_en = 1'b1;
        exp_start(3, t + 5);
        exp_done(t + 27);
        at_cyc(t + 21);
        chk("timeout_not_yet", {30'd0, err_timeout, busy}, 32'b01);
        at_cyc(t + 22);
        chk("timeout_set", 32'(err_timeout), 32'd1);
        at_cyc(t + 30);
        scan_en = 1'b0;
        chk("valid_f7", 32'(valid), 32'hF7);
        chk("no_overrun", 32'(err_overrun), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_timeout", 32'(err_timeout), 32'd0);

        // Silent converter, all channels: scan outlasts the period.
        at_cyc(cyc + 5);
        chnl_mask = 8'hFF;
        for (int i = 0; i < 8; i++) lat[i] = 0;
        t = cyc + P - 1;
        scan_en = 1'b1;
        for (int k = 0; k < 8; k++) exp_start(k, t + 2 + 19 * k);
        exp_done(t + 153);
        at_cyc(t + P);
        chk("overrun_not_yet", {30'd0, err_overrun, busy}, 32'b01);
        at_cyc(t + P + 1);
        chk("overrun_set", 32'(err_overrun), 32'd1);
        at_cyc(t + 160);
        scan_en = 1'b0;
        chk("valid_00", 32'(valid), 32'h00);
        chk("timeout_again", 32'(err_timeout), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_both", {30'd0, err_timeout, err_overrun}, 32'd0);

        // Empty mask: no activity for 500 clocks.
        at_cyc(cyc + 5);
        chnl_mask = 8'h00;
        scan_en = 1'b1;
        busy_cnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        scan_en = 1'b0;
        chk("mask0_busy_cycles", busy_cnt, 0);

        // Mask change mid-scan leaves the sequence untouched.
        at_cyc(cyc + 5);
        chnl_mask = 8'h05;
        lat[0] = 10; rv[0] = 12'h321;
        lat[2] = 10; rv[2] = 12'h654;
        t = cyc + P - 1;
        scan_en = 1'b1;
        exp_start(0, t + 2); exp_start(2, t + 16); exp_done(t + 33);
        at_cyc(t + 5);
        chnl_mask = 8'hFA;
        at_cyc(t + 40);
        scan_en = 1'b0;
        chk("valid_midmask", 32'(valid), 32'h05);
        rd_chnl = 3'd2; #1;
        chk("rd_ch2_midmask", 32'(rd_data), 32'h654);

        // Asynchronous reset while in CONV.
        at_cyc(cyc + 5);
        rd_chnl = 3'd0;
        chnl_mask = 8'h01;
        lat[0] = 0;
        t = cyc + P - 1;
        scan_en = 1'b1;
        exp_start(0, t + 2);
        at_cyc(t + 6);
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {strt_cnv, chnnl, busy, scan_done, valid, err_timeout, err_overrun, rd_data}, 32'd0);
        chnl_mask = 8'h05;
        lat[0] = 10; rv[0] = 12'h111;
        lat[2] = 10; rv[2] = 12'h222;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = cyc + P - 1;
        exp_start(0, t + 2); exp_start(2, t + 16); exp_done(t + 33);
        at_cyc(t + 40);
        scan_en = 1'b0;
        chk("valid_after_reset", 32'(valid), 32'h05);
        rd_chnl = 3'd0; #1;
        chk("rd_ch0_after_reset", 32'(rd_data), 32'h111);

        at_cyc(cyc + 10);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a2d_scan_sched.md
Name: a2d_scan_sched

Overview:
- Autonomous scan scheduler sitting in front of the SPI A2D converter interface. It owns that interface's strt_cnv/chnnl/cnv_cmplt/res handshake.
- On a periodic tick it walks the enabled channels 0..7 in ascending order and starts one conversion per channel. Each 12-bit result is stored in a per-channel register.
- The rest of the design reads results by channel index and gets a scan-complete pulse, valid bits and error flags.

Parameters:
- SCAN_PERIOD, 50000, clocks between scan-start ticks (1 ms at 50 MHz); must be >= 2.
- TIMEOUT, 4096, max clocks spent in CONV waiting for cnv_cmplt before the channel is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  enables the period timer and new scans
- chnl_mask  in  8  bit n=1 enables channel n; sampled at scan start
- clr_err  in  1  clears err_timeout and err_overrun
- rd_chnl  in  3  readback channel select
- rd_data  out  12  result register of rd_chnl (combinational mux)
- valid  out  8  bit n set once channel n holds a good result
- scan_done  out  1  one-clock pulse at the end of each scan
- busy  out  1  high whenever state != IDLE
- err_timeout  out  1  sticky: a conversion timed out
- err_overrun  out  1  sticky: a tick arrived while busy
- strt_cnv  out  1  one-clock conversion start to the A2D interface
- chnnl  out  3  channel to convert; held stable from START through CONV
- cnv_cmplt  in  1  conversion-complete pulse from the A2D interface
- res  in  12  conversion result, valid when cnv_cmplt=1

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low. Every flop uses posedge clk / negedge rst_n.
- Reset values: all outputs 0; result registers 0; timer 0; ptr 0; state IDLE.
- Period timer:
  - Counts 0..SCAN_PERIOD-1 and wraps while scan_en=1.
  - Held at 0 while scan_en=0.
  - tick=1 for the one cycle the timer equals SCAN_PERIOD-1.
- State machine (Moore outputs): IDLE, SEL, START, CONV, NEXT, DONE.
- IDLE:
  - If tick and scan_en and chnl_mask!=0: latch chnl_mask into scan_mask, ptr<=0, go to SEL.
  - If tick and chnl_mask==0: stay in IDLE; no scan_done.
- SEL:
  - If scan_mask[ptr]=1, go to START.
  - Else if ptr==7, go to DONE.
  - Else ptr<=ptr+1 and stay in SEL (one clock per skipped channel).
- START:
  - strt_cnv=1 for exactly this cycle; chnnl=ptr.
  - Clear the watchdog counter and go to CONV.
- CONV:
  - chnnl=ptr held. Watchdog increments each cycle.
  - If cnv_cmplt=1: result[ptr]<=res, valid[ptr]<=1, go to NEXT. cnv_cmplt takes priority over a coincident watchdog expiry.
  - Else if watchdog==TIMEOUT-1: err_timeout<=1, valid[ptr]<=0, go to NEXT.
- NEXT: if ptr==7 go to DONE, else ptr<=ptr+1 and go to SEL.
- DONE: scan_done=1 for one cycle, then go to IDLE.
- Latency: with channel 0 enabled, strt_cnv rises 2 clocks after the tick cycle. Going from cnv_cmplt to the next strt_cnv takes 3 clocks (NEXT, SEL, START).
- chnl_mask changes mid-scan have no effect until the next scan.
- scan_en=0 mid-scan: the current scan completes normally and no new scan starts.
- Tick while busy: the tick is ignored and err_overrun<=1.
- clr_err=1 clears both error flags. A simultaneous set wins, so the flag stays 1.
- cnv_cmplt outside CONV is ignored.
- valid bits are cleared only by reset, or by a timeout on that channel.
- rd_data tracks rd_chnl combinationally. A result register updates in the clock edge at the end of its CONV cycle.
- Asynchronous reset mid-conversion returns to IDLE immediately with strt_cnv=0.

Test Plan:
- Reset, SCAN_PERIOD=100, mask=8'h05, scan_en=1, model returns res=12'h123 (ch0) and 12'hABC (ch2) 20 clocks after strt_cnv:
  - exactly 2 strt_cnv pulses, with chnnl=0 then chnnl=2;
  - valid=8'h05;
  - rd_chnl=2 gives rd_data=12'hABC;
  - one scan_done pulse per 100-clock period.
- mask=8'hFF, res=12'h800+channel: 8 conversions in order 0..7; all valid bits set; readback matches for every channel; strt_cnv is 2 clocks after tick.
- TIMEOUT=16, model never answers ch3, mask=8'h08:
  - after 16 CONV clocks, err_timeout=1 and valid[3]=0;
  - scan_done still pulses;
  - clr_err clears err_timeout.
- Conversion latency 150 > SCAN_PERIOD=100: err_overrun=1, and no second scan starts until the current one reaches DONE.
- mask=8'h00: no strt_cnv and no scan_done over 500 clocks, and busy stays 0. Changing the mask mid-scan does not alter the channel sequence.
- Assert rst_n=0 in CONV: all outputs return to 0 asynchronously. After release, the first scan starts on the next tick from ptr=0.
